// File: rtl/lcd_regpanel.sv
// lcd_regpanel: RGB565 raster timing generator that draws NREG registers of RW bits as a grid of cells.
// Optional macro LCD_REGPANEL_BLINK_EN: rows selected by blink_mask blink with bit 5 of a 6-bit frame counter.
module lcd_regpanel #(
  parameter int H_SYNC    = 1,
  parameter int H_BP      = 181,
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 210,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 3,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 42,
  parameter int NREG      = 8,
  parameter int RW        = 8,
  parameter int CELL_LOG2 = 5,
  parameter int GAP       = 4,
  parameter int X0        = 128,
  parameter int Y0        = 8,
  localparam int RSW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            PixelClk,
  input  logic            RST,
  output logic [RSW-1:0]  regsel,
  input  logic [RW-1:0]   regdat,
  input  logic [NREG-1:0] blink_mask,
  output logic            LCD_HSYNC,
  output logic            LCD_VSYNC,
  output logic            LCD_DE,
  output logic [4:0]      LCD_R,
  output logic [5:0]      LCD_G,
  output logic [4:0]      LCD_B,
  output logic            sof
);
  localparam int HT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  localparam int PW  = RW << CELL_LOG2;
  localparam int PH  = NREG << CELL_LOG2;
  localparam int XW  = HW + 2;
  localparam int YW  = VW + 2;
  localparam int CSW = (RW > 1) ? $clog2(RW) : 1;

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == HW'(HT - 1)) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == VW'(VT - 1)) ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  logic                 w_hsync0, w_vsync0, w_de0, w_sof0;
  logic                 w_row_ok, w_in_panel, w_lit0, w_bit0;
  logic signed [XW-1:0] w_px;
  logic signed [YW-1:0] w_py;
  logic [CSW-1:0]       w_col;
  logic [RSW-1:0]       w_row;

  assign w_hsync0 = (r_hcnt >= HW'(H_SYNC));
  assign w_vsync0 = (r_vcnt >= VW'(V_SYNC));
  assign w_de0    = (r_hcnt >= HW'(HA0)) && (r_hcnt < HW'(HA0 + H_ACTIVE)) &&
                    (r_vcnt >= VW'(VA0)) && (r_vcnt < VW'(VA0 + V_ACTIVE));
  assign w_sof0   = (r_hcnt == '0) && (r_vcnt == '0);

  // Panel-relative coordinates; negative values mean left of / above the panel
  assign w_px       = $signed({2'b00, r_hcnt}) - $signed(XW'(HA0 + X0));
  assign w_py       = $signed({2'b00, r_vcnt}) - $signed(YW'(VA0 + Y0));
  assign w_row_ok   = !w_py[YW-1] && (w_py < $signed(YW'(PH)));
  assign w_in_panel = w_de0 && w_row_ok && !w_px[XW-1] && (w_px < $signed(XW'(PW)));
  assign w_col      = CSW'(w_px >>> CELL_LOG2);
  assign w_row      = RSW'(w_py >>> CELL_LOG2);
  assign w_lit0     = w_in_panel && (int'(w_px[CELL_LOG2-1:0]) >= GAP) &&
                      (int'(w_py[CELL_LOG2-1:0]) >= GAP);
  assign regsel     = (RST || !w_row_ok) ? '0 : w_row;

  always_comb begin
    w_bit0 = 1'b0;
    for (int i = 0; i < RW; i++) begin
      w_bit0 = (w_col == CSW'(i)) ? regdat[RW-1-i] : w_bit0;
    end
  end

  logic           r_bit1, r_lit1, r_de1, r_hs1, r_vs1, r_sof1;
  logic [RSW-1:0] r_row1;

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_bit1 <= 1'b0;
      r_lit1 <= 1'b0;
      r_de1  <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_sof1 <= 1'b0;
      r_row1 <= '0;
    end else begin
      r_bit1 <= w_bit0;
      r_lit1 <= w_lit0;
      r_de1  <= w_de0;
      r_hs1  <= w_hsync0;
      r_vs1  <= w_vsync0;
      r_sof1 <= w_sof0;
      r_row1 <= w_row;
    end
  end

  logic w_eff1;
`ifdef LCD_REGPANEL_BLINK_EN
  logic [5:0] r_fcnt;

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_fcnt <= 6'd0;
    end else if (r_sof1) begin
      r_fcnt <= r_fcnt + 6'd1;
    end
  end

  assign w_eff1 = r_bit1 && !(blink_mask[r_row1] && r_fcnt[5]);
`else
  logic w_unused;
  assign w_unused = ^{blink_mask, r_row1};
  assign w_eff1   = r_bit1;
`endif

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_DE    <= 1'b0;
      LCD_R     <= 5'd0;
      LCD_G     <= 6'd0;
      LCD_B     <= 5'd0;
      sof       <= 1'b0;
    end else begin
      LCD_HSYNC <= r_hs1;
      LCD_VSYNC <= r_vs1;
      LCD_DE    <= r_de1;
      LCD_R     <= (r_lit1 && w_eff1) ? 5'd31 : 5'd0;
      LCD_G     <= (r_lit1 && w_eff1) ? 6'd63 : 6'd0;
      LCD_B     <= r_lit1 ? 5'd31 : 5'd0;
      sof       <= r_sof1;
    end
  end

endmodule

// File: tb/tb_lcd_regpanel.sv
// Directed bench for lcd_regpanel: a default-geometry instance (A) and a miniature instance (B)
// whose short frames make frame-level behaviour (sof period, blinking, panel bottom edge) reachable.
module tb_lcd_regpanel;
  localparam int unsigned HTA = 1192;
  localparam int unsigned HTB = 24;
  localparam int unsigned FTB = 336;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] BLACK = 16'h0000;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_regsel;
  logic [7:0] a_regdat = 8'hA5;
  logic [7:0] a_blink  = 8'h00;
  logic       a_hs, a_vs, a_de, a_sof;
  logic [4:0] a_r, a_b;
  logic [5:0] a_g;
  logic [0:0] b_regsel;
  logic [1:0] b_regdat = 2'b11;
  logic [1:0] b_blink  = 2'b01;
  logic       b_hs, b_vs, b_de, b_sof;
  logic [4:0] b_r, b_b;
  logic [5:0] b_g;
  wire [15:0] a_rgb = {a_r, a_g, a_b};
  wire [15:0] b_rgb = {b_r, b_g, b_b};

  lcd_regpanel u_a (
    .PixelClk(clk), .RST(RST), .regsel(a_regsel), .regdat(a_regdat), .blink_mask(a_blink),
    .LCD_HSYNC(a_hs), .LCD_VSYNC(a_vs), .LCD_DE(a_de), .LCD_R(a_r), .LCD_G(a_g), .LCD_B(a_b),
    .sof(a_sof)
  );

  lcd_regpanel #(
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(16), .H_FP(3), .V_SYNC(1), .V_BP(1), .V_ACTIVE(10), .V_FP(2),
    .NREG(2), .RW(2), .CELL_LOG2(2), .GAP(1), .X0(2), .Y0(1)
  ) u_b (
    .PixelClk(clk), .RST(RST), .regsel(b_regsel), .regdat(b_regdat), .blink_mask(b_blink),
    .LCD_HSYNC(b_hs), .LCD_VSYNC(b_vs), .LCD_DE(b_de), .LCD_R(b_r), .LCD_G(b_g), .LCD_B(b_b),
    .sof(b_sof)
  );

  int unsigned cyc;
  int vec;
  int err;

  // cyc counts rising edges since the last reset release; outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) step();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vec++;
    if ({a_hs, a_vs, a_de, a_rgb, a_sof, a_regsel} !== {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 3'd0}) begin
      err++; $display("FAIL reset_a: got %h want %h", {a_hs, a_vs, a_de, a_rgb, a_sof, a_regsel}, {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 3'd0});
    end
    vec++;
    if ({b_hs, b_vs, b_de, b_rgb, b_sof, b_regsel} !== {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 1'b0}) begin
      err++; $display("FAIL reset_b: got %h want %h", {b_hs, b_vs, b_de, b_rgb, b_sof, b_regsel}, {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 1'b0});
    end
    @(negedge clk);
    RST = 1'b0;
    cyc = 0;
  endtask

  // sof goes high on edge 2 after release, so the 3rd edge is the first to sample it
  task automatic test_sync_timing();
    run_to(1);
    vec++; if (a_sof !== 1'b0) begin err++; $display("FAIL sof_edge1: got %b want 0", a_sof); end
    run_to(2);
    vec++; if (a_sof !== 1'b1) begin err++; $display("FAIL sof_edge2: got %b want 1", a_sof); end
    vec++; if (a_hs !== 1'b0) begin err++; $display("FAIL hsync_first: got %b want 0", a_hs); end
    vec++; if (a_vs !== 1'b0) begin err++; $display("FAIL vsync_first: got %b want 0", a_vs); end
    vec++; if (b_sof !== 1'b1) begin err++; $display("FAIL b_sof_edge2: got %b want 1", b_sof); end
    run_to(3);
    vec++; if (a_sof !== 1'b0) begin err++; $display("FAIL sof_edge3: got %b want 0", a_sof); end
    vec++; if (a_hs !== 1'b1) begin err++; $display("FAIL hsync_width: got %b want 1", a_hs); end
    run_to(FTB + 1);
    vec++; if (b_sof !== 1'b0) begin err++; $display("FAIL b_sof_pre: got %b want 0", b_sof); end
    run_to(FTB + 2);
    vec++; if (b_sof !== 1'b1) begin err++; $display("FAIL b_sof_period: got %b want 1", b_sof); end
    run_to(HTA + 1);
    vec++; if (a_hs !== 1'b1) begin err++; $display("FAIL hsync_pre: got %b want 1", a_hs); end
    run_to(HTA + 2);
    vec++; if (a_hs !== 1'b0) begin err++; $display("FAIL hsync_period: got %b want 0", a_hs); end
    run_to(HTA + 3);
    vec++; if (a_hs !== 1'b1) begin err++; $display("FAIL hsync_post: got %b want 1", a_hs); end
    run_to(5 * HTA + 1);
    vec++; if (a_vs !== 1'b0) begin err++; $display("FAIL vsync_last: got %b want 0", a_vs); end
    run_to(5 * HTA + 2);
    vec++; if (a_vs !== 1'b1) begin err++; $display("FAIL vsync_end: got %b want 1", a_vs); end
  endtask

  task automatic test_de_count();
    int cnt7, cnt8, first8, last8;
    cnt7 = 0; cnt8 = 0; first8 = -1; last8 = -1;
    for (int unsigned n = 7 * HTA; n < 9 * HTA; n++) begin
      run_to(n + 2);
      if (a_de === 1'b1) begin
        if (n < 8 * HTA) cnt7++;
        else begin
          cnt8++;
          if (first8 < 0) first8 = int'(n - 8 * HTA);
          last8 = int'(n - 8 * HTA);
        end
      end
    end
    vec++; if (cnt7 != 0) begin err++; $display("FAIL de_line7: got %0d want 0", cnt7); end
    vec++; if (cnt8 != 800) begin err++; $display("FAIL de_line8: got %0d want 800", cnt8); end
    vec++; if (first8 != 182) begin err++; $display("FAIL de_first: got %0d want 182", first8); end
    vec++; if (last8 != 981) begin err++; $display("FAIL de_last: got %0d want 981", last8); end
  endtask

  task automatic test_pixels_a();
    int unsigned ax_l[7]   = '{132, 135, 160, 164, 196, 383, 384};
    logic [15:0] exp_l[7]  = '{WHITE, WHITE, BLACK, BLUE, WHITE, WHITE, BLACK};
    int unsigned n;
    n = 19 * HTA + 182 + 132;
    run_to(n + 2);
    vec++; if (a_rgb !== BLACK) begin err++; $display("FAIL a_top_gap: got %h want %h", a_rgb, BLACK); end
    n = 20 * HTA + 182 + 132;
    run_to(n);
    vec++; if (a_regsel !== 3'd0) begin err++; $display("FAIL a_regsel: got %0d want 0", a_regsel); end
    for (int i = 0; i < 7; i++) begin
      run_to(20 * HTA + 182 + ax_l[i] + 2);
      vec++;
      if (a_rgb !== exp_l[i]) begin
        err++; $display("FAIL a_pix ax=%0d ay=12: got %h want %h", ax_l[i], a_rgb, exp_l[i]);
      end
    end
    for (int unsigned ax = 128; ax < 132; ax++) begin
      run_to(21 * HTA + 182 + ax + 2);
      vec++;
      if ({a_de, a_rgb} !== {1'b1, BLACK}) begin
        err++; $display("FAIL a_left_gap ax=%0d: got de=%b rgb=%h want de=1 rgb=%h", ax, a_de, a_rgb, BLACK);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int unsigned n;
    n = (cyc / FTB + 1) * FTB + 5 * HTB + 12;
    run_to(n);
    @(negedge clk);
    RST = 1'b1;
    #1;
    vec++;
    if ({a_hs, a_vs, a_de, a_rgb, a_sof, a_regsel} !== {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 3'd0}) begin
      err++; $display("FAIL midreset_a: got %h want %h", {a_hs, a_vs, a_de, a_rgb, a_sof, a_regsel}, {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 3'd0});
    end
    vec++;
    if ({b_hs, b_vs, b_de, b_rgb, b_sof, b_regsel} !== {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 1'b0}) begin
      err++; $display("FAIL midreset_b: got %h want %h", {b_hs, b_vs, b_de, b_rgb, b_sof, b_regsel}, {1'b1, 1'b1, 1'b0, BLACK, 1'b0, 1'b0});
    end
    repeat (3) @(negedge clk);
    RST = 1'b0;
    cyc = 0;
    run_to(1);
    vec++; if ({a_sof, b_sof} !== 2'b00) begin err++; $display("FAIL rerun_sof1: got %b want 00", {a_sof, b_sof}); end
    run_to(2);
    vec++; if ({a_sof, b_sof, a_hs, b_hs} !== 4'b1100) begin err++; $display("FAIL rerun_sof2: got %b want 1100", {a_sof, b_sof, a_hs, b_hs}); end
    run_to(3);
    vec++; if ({a_sof, a_hs, b_hs} !== 3'b010) begin err++; $display("FAIL rerun_edge3: got %b want 010", {a_sof, a_hs, b_hs}); end
    run_to(4);
    vec++; if (b_hs !== 1'b1) begin err++; $display("FAIL rerun_b_hs: got %b want 1", b_hs); end
    run_to(HTB + 2);
    vec++; if (b_hs !== 1'b0) begin err++; $display("FAIL rerun_b_hperiod: got %b want 0", b_hs); end
  endtask

  // Frame 1 after the mid-frame reset: fcnt=2, so nothing blinks here
  task automatic test_pixels_b();
    run_to(FTB + 105);
    vec++; if (b_regsel !== 1'b0) begin err++; $display("FAIL b_regsel_row0: got %b want 0", b_regsel); end
    run_to(FTB + 107);
    vec++; if (b_rgb !== WHITE) begin err++; $display("FAIL b_row0_pix: got %h want %h", b_rgb, WHITE); end
    run_to(FTB + 129);
    vec++; if (b_rgb !== BLACK) begin err++; $display("FAIL b_left_gap: got %h want %h", b_rgb, BLACK); end
    run_to(FTB + 201);
    vec++; if (b_regsel !== 1'b1) begin err++; $display("FAIL b_regsel_row1: got %b want 1", b_regsel); end
    run_to(FTB + 203);
    vec++; if (b_rgb !== WHITE) begin err++; $display("FAIL b_row1_pix: got %h want %h", b_rgb, WHITE); end
    run_to(FTB + 273);
    vec++; if (b_regsel !== 1'b0) begin err++; $display("FAIL b_regsel_below: got %b want 0", b_regsel); end
    run_to(FTB + 275);
    vec++;
    if ({b_de, b_rgb} !== {1'b1, BLACK}) begin
      err++; $display("FAIL b_below_panel: got de=%b rgb=%h want de=1 rgb=%h", b_de, b_rgb, BLACK);
    end
  endtask

  task automatic test_blink();
    int unsigned frames[3] = '{2, 40, 60};
    logic [15:0] exp0;
    for (int i = 0; i < 3; i++) begin
`ifdef LCD_REGPANEL_BLINK_EN
      exp0 = (frames[i] >= 32) ? BLUE : WHITE;
`else
      exp0 = WHITE;
`endif
      run_to(frames[i] * FTB + 107);
      vec++;
      if (b_rgb !== exp0) begin
        err++; $display("FAIL blink_row0 frame=%0d: got %h want %h", frames[i], b_rgb, exp0);
      end
      run_to(frames[i] * FTB + 203);
      vec++;
      if (b_rgb !== WHITE) begin
        err++; $display("FAIL blink_row1 frame=%0d: got %h want %h", frames[i], b_rgb, WHITE);
      end
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    cyc = 0;
    test_reset();
    test_sync_timing();
    test_de_count();
    test_pixels_a();
    test_midframe_reset();
    test_pixels_b();
    test_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
